// File: rtl/timer_ctrl_seq_pkg.sv
// Shared definitions for the timer command sequencer: op codes, timer register
// map, control-word bit positions and the sequencer state encoding.
package timer_ctrl_seq_pkg;

  localparam logic [1:0] OP_CONFIG   = 2'd0;
  localparam logic [1:0] OP_STOP     = 2'd1;
  localparam logic [1:0] OP_SNAPSHOT = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WR_STOP,
    S_WR_SNAP,
    S_RD_SL,
    S_RD_SH,
    S_RD_DONE,
    S_ACK,
    S_ACK_WAIT
  } state_e;

  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop;
    w[CTRL_START] = start;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_seq_satcnt.sv
// 16-bit counter that sticks at all-ones; clear takes priority over increment.
module timer_ctrl_seq_satcnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/timer_ctrl_seq.sv
// Command sequencer driving a 16-bit timer register port: CONFIG/STOP/SNAPSHOT
// plus IRQ acknowledge. SNAPSHOT exists only with TIMER_CTRL_SEQ_SNAPSHOT_EN.
module timer_ctrl_seq
  import timer_ctrl_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_irq_en,
  output logic        cmd_err,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic [31:0] snap_value,
  output logic        snap_valid,
  output logic [15:0] timeout_count,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] period_q;
  logic        cont_q, ito_q;
  logic        err_q;
  logic        accept;
  logic        cmd_good;

  assign cmd_ready = (state_q == S_IDLE) && !tmr_irq;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    cmd_good = 1'b0;
    case (cmd_op)
      OP_CONFIG:   cmd_good = (cmd_period != 32'd0);
      OP_STOP:     cmd_good = 1'b1;
`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
      OP_SNAPSHOT: cmd_good = 1'b1;
`endif
      default:     cmd_good = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An IRQ seen in IDLE always wins; it also masks cmd_ready, so no command slips in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tmr_irq) begin
          state_d = S_ACK;
        end else if (accept && cmd_good) begin
          case (cmd_op)
            OP_CONFIG:   state_d = S_WR_PL;
            OP_STOP:     state_d = S_WR_STOP;
`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
            OP_SNAPSHOT: state_d = S_WR_SNAP;
`endif
            default:     state_d = S_IDLE;
          endcase
        end
      end
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CTRL;
      S_WR_CTRL:  state_d = S_IDLE;
      S_WR_STOP:  state_d = S_IDLE;
`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
      S_WR_SNAP:  state_d = S_RD_SL;
      S_RD_SL:    state_d = S_RD_SH;
      S_RD_SH:    state_d = S_RD_DONE;
      S_RD_DONE:  state_d = S_IDLE;
`endif
      S_ACK:      state_d = S_ACK_WAIT;
      S_ACK_WAIT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = '0;
    tmr_writedata  = '0;
    case (state_q)
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_PERIODL;
        tmr_writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_PERIODH;
        tmr_writedata  = period_q[31:16];
      end
      S_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_CONTROL;
        tmr_writedata  = ctrl_word(1'b0, 1'b1, cont_q, ito_q);
      end
      S_WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_CONTROL;
        tmr_writedata  = ctrl_word(1'b1, 1'b0, cont_q, ito_q);
      end
`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
      S_WR_SNAP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_SNAPL;
      end
      S_RD_SL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = REG_SNAPL;
      end
      S_RD_SH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = REG_SNAPH;
      end
`endif
      S_ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = REG_STATUS;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
      cont_q   <= 1'b0;
      ito_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !cmd_good;
      if (accept && cmd_good && (cmd_op == OP_CONFIG)) begin
        period_q <= cmd_period;
        cont_q   <= cmd_continuous;
        ito_q    <= cmd_irq_en;
      end
    end
  end

  assign cmd_err = err_q;

`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
  logic [15:0] snap_lo_q;
  logic [31:0] snap_value_q;
  logic        snap_valid_q;

  // Read data lags the address by a cycle, so each half lands one state later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= (state_q == S_RD_DONE);
      if (state_q == S_RD_SH) begin
        snap_lo_q <= tmr_readdata;
      end
      if (state_q == S_RD_DONE) begin
        snap_value_q <= {tmr_readdata, snap_lo_q};
      end
    end
  end

  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^tmr_readdata;
  assign snap_value      = '0;
  assign snap_valid      = 1'b0;
`endif

  timer_ctrl_seq_satcnt u_timeout_cnt (
    .clk     (clk),
    .rst     (reset),
    .clear_i (1'b0),
    .inc_i   (state_q == S_ACK),
    .count_o (timeout_count)
  );

endmodule

// File: tb/tb_timer_ctrl_seq.sv
// Scoreboard bench for timer_ctrl_seq: expected bus accesses are queued as
// commands are issued and matched by a bus monitor on every falling edge.
module tb_timer_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_period = 32'd0;
  logic        cmd_continuous = 1'b0;
  logic        cmd_irq_en = 1'b0;
  logic        cmd_err;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq = 1'b0;
  logic [31:0] snap_value;
  logic        snap_valid;
  logic [15:0] timeout_count;
  logic        busy;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        wn;
  } bus_t;

  bus_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tc_exp = 16'd0;

  timer_ctrl_seq dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_period     (cmd_period),
    .cmd_continuous (cmd_continuous),
    .cmd_irq_en     (cmd_irq_en),
    .cmd_err        (cmd_err),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .snap_value     (snap_value),
    .snap_valid     (snap_valid),
    .timeout_count  (timeout_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Timer model: registered read data for the snapshot registers.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n) begin
      case (tmr_address)
        3'd4:    tmr_readdata <= 16'h1234;
        3'd5:    tmr_readdata <= 16'h0005;
        default: tmr_readdata <= 16'h0000;
      endcase
    end else begin
      tmr_readdata <= 16'h0000;
    end
  end

  always @(negedge clk) begin
    bus_t got;
    bus_t exp;
    if (!reset && tmr_chipselect) begin
      got = {tmr_address, tmr_writedata, tmr_write_n};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected got addr=%0d data=%h wn=%b required no access",
                 tmr_address, tmr_writedata, tmr_write_n);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL bus_access got addr=%0d data=%h wn=%b required addr=%0d data=%h wn=%b",
                   got.addr, got.data, got.wn, exp.addr, exp.data, exp.wn);
        end else begin
          $display("bus addr=%0d data=%h wn=%b ok", got.addr, got.data, got.wn);
        end
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per,
                          input logic cont, input logic ito);
    bit done;
    done           = 1'b0;
    cmd_op         = op;
    cmd_period     = per;
    cmd_continuous = cont;
    cmd_irq_en     = ito;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cmd_accept got timeout required acceptance op=%0d", op);
    end else begin
      $display("cmd op=%0d period=%h accepted", op, per);
    end
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 30) begin
      @(negedge clk);
      #1;
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending accesses required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 3'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_bus got cs=%b wn=%b addr=%0d data=%h required cs=0 wn=1 addr=0 data=0",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    checks++;
    if ({busy, cmd_ready, cmd_err, snap_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags got busy=%b ready=%b err=%b snapv=%b required 0 1 0 0",
               busy, cmd_ready, cmd_err, snap_valid);
    end
    checks++;
    if (timeout_count !== 16'd0 || snap_value !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got tc=%h snap=%h required 0 0", timeout_count, snap_value);
    end
    reset = 1'b0;
    $display("reset done");
  endtask

  task automatic test_config();
    int busy_n;
    busy_n = 0;
    exp_q.push_back({3'd2, 16'h86A0, 1'b0});
    exp_q.push_back({3'd3, 16'h0001, 1'b0});
    exp_q.push_back({3'd1, 16'h0007, 1'b0});
    send_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (n == 3) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL config_ready4 got %b required 1", cmd_ready);
        end
      end
    end
    checks++;
    if (busy_n != 3) begin
      errors++;
      $display("FAIL config_busy got %0d cycles required 3", busy_n);
    end
    wait_drain("config");
  endtask

  task automatic test_reject();
    send_cmd(2'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_zero got err=%b busy=%b required err=1 busy=0", cmd_err, busy);
    end
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse got err=%b required 0", cmd_err);
    end
    send_cmd(2'd3, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_rsvd got err=%b required 1", cmd_err);
    end
  endtask

  task automatic test_stop();
    // Shadow bits come from the last accepted CONFIG (cont=1, ito=1).
    exp_q.push_back({3'd1, 16'h000B, 1'b0});
    send_cmd(2'd1, 32'd0, 1'b0, 1'b0);
    wait_drain("stop");
  endtask

  task automatic test_irq();
    bit seen;
    seen = 1'b0;
    tc_exp = tc_exp + 16'd1;
    exp_q.push_back({3'd0, 16'h0000, 1'b0});
    @(negedge clk);
    tmr_irq = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (tmr_chipselect && tmr_address == 3'd0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL irq_ack got none required ack write");
    end
    @(negedge clk);
    tmr_irq = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_count !== tc_exp) begin
      errors++;
      $display("FAIL irq_count got %0d required %0d", timeout_count, tc_exp);
    end
    wait_drain("irq");
  endtask

  task automatic test_collision();
    int  ack_at;
    int  acc_at;
    bit  acc;
    ack_at = -1;
    acc_at = -1;
    acc    = 1'b0;
    tc_exp = tc_exp + 16'd1;
    exp_q.push_back({3'd0, 16'h0000, 1'b0});
    exp_q.push_back({3'd2, 16'h0005, 1'b0});
    exp_q.push_back({3'd3, 16'h0000, 1'b0});
    exp_q.push_back({3'd1, 16'h0004, 1'b0});
    @(negedge clk);
    cmd_op = 2'd0; cmd_period = 32'd5; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
    cmd_valid = 1'b1;
    tmr_irq   = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (ack_at >= 0 && i == ack_at + 1) tmr_irq = 1'b0;
      if (tmr_chipselect && tmr_address == 3'd0 && !tmr_write_n && ack_at < 0) ack_at = i;
      if (cmd_ready) begin
        acc_at = i;
        acc = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    tmr_irq   = 1'b0;
    checks++;
    if (ack_at != 0 || acc_at != 2) begin
      errors++;
      $display("FAIL collision_order got ack@%0d accept@%0d required ack@0 accept@2", ack_at, acc_at);
    end
    wait_drain("collision");
    checks++;
    if (timeout_count !== tc_exp) begin
      errors++;
      $display("FAIL collision_count got %0d required %0d", timeout_count, tc_exp);
    end
  endtask

  task automatic test_snapshot();
`ifdef TIMER_CTRL_SEQ_SNAPSHOT_EN
    bit got;
    got = 1'b0;
    exp_q.push_back({3'd4, 16'h0000, 1'b0});
    exp_q.push_back({3'd4, 16'h0000, 1'b1});
    exp_q.push_back({3'd5, 16'h0000, 1'b1});
    send_cmd(2'd2, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (snap_valid) got = 1'b1;
    end
    checks++;
    if (!got || snap_value !== 32'h0005_1234) begin
      errors++;
      $display("FAIL snap_value got valid=%b value=%h required 1 00051234", got, snap_value);
    end
    @(negedge clk);
    checks++;
    if (snap_valid !== 1'b0) begin
      errors++;
      $display("FAIL snap_pulse got %b required 0", snap_valid);
    end
    wait_drain("snapshot");
`else
    send_cmd(2'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_err !== 1'b1 || snap_valid !== 1'b0 || snap_value !== 32'd0) begin
      errors++;
      $display("FAIL snap_reject got err=%b valid=%b value=%h required 1 0 0",
               cmd_err, snap_valid, snap_value);
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({3'd2, 16'h0003, 1'b0});
    exp_q.push_back({3'd3, 16'h0002, 1'b0});
    send_cmd(2'd0, 32'h0002_0003, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tmr_chipselect !== 1'b1 || tmr_address !== 3'd3) begin
      errors++;
      $display("FAIL midrst_phase got cs=%b addr=%0d required cs=1 addr=3", tmr_chipselect, tmr_address);
    end
    #2 reset = 1'b1;
    #1;
    tc_exp = 16'd0;
    checks++;
    if (tmr_chipselect !== 1'b0 || busy !== 1'b0 || tmr_write_n !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bus got cs=%b busy=%b wn=%b required 0 0 1", tmr_chipselect, busy, tmr_write_n);
    end
    checks++;
    if (timeout_count !== tc_exp) begin
      errors++;
      $display("FAIL midrst_count got %0d required %0d", timeout_count, tc_exp);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_after got busy=%b pending=%0d required 0 0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_reject();
    test_stop();
    test_irq();
    test_collision();
    test_snapshot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
